// File: rtl/st7920_pkg.sv
// Shared types and geometry for the ST7920 128x64 framebuffer engine.
package st7920_pkg;

  localparam int unsigned FB_W          = 128;
  localparam int unsigned FB_H          = 64;
  localparam int unsigned FB_BYTES      = FB_W * FB_H / 8;
  localparam int unsigned BYTES_PER_ROW = FB_W / 8;

  localparam int unsigned X_W    = 7;
  localparam int unsigned Y_W    = 6;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned POS_W  = 8;

  typedef enum logic [1:0] {
    FB_CLEAR = 2'd0,
    FB_PIXEL = 2'd1,
    FB_HLINE = 2'd2,
    FB_VLINE = 2'd3
  } fb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HLINE = 3'd2,
    ST_VLINE = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_t;

  typedef struct packed {
    fb_op_t           op;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [LEN_W-1:0] len;
    logic             color;
  } fb_cmd_t;

endpackage

// File: rtl/fb_pixel_addr.sv
// Maps a pixel coordinate to its framebuffer byte and bit (MSB = leftmost pixel).
module fb_pixel_addr
  import st7920_pkg::*;
(
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] byte_idx_o,
  output logic [2:0]        bit_idx_o
);

  // byte = y*16 + x/8, bit = 7 - x%8
  assign byte_idx_o = {y_i, x_i[X_W-1:3]};
  assign bit_idx_o  = ~x_i[2:0];

endmodule

// File: rtl/fb_draw_engine.sv
// Framebuffer owner and draw engine: CLEAR/PIXEL/HLINE/VLINE into a 1024-byte image.
module fb_draw_engine
  import st7920_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [X_W-1:0]   cmd_x,
  input  logic [Y_W-1:0]   cmd_y,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_color,
  output logic             done,
  output logic [7:0]       frame_out [0:FB_BYTES-1]
);

  fb_state_t         state_q;
  logic              done_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [POS_W-1:0]  pos_x_q;
  logic [POS_W-1:0]  pos_y_q;
  logic [LEN_W-1:0]  len_q;
  logic              color_q;
  logic [7:0]        fb_q [0:FB_BYTES-1];

  fb_cmd_t           cmd_c;
  logic [X_W-1:0]    draw_x_c;
  logic [Y_W-1:0]    draw_y_c;
  logic [ADDR_W-1:0] byte_idx_c;
  logic [2:0]        bit_idx_c;

  // Bundle the incoming command fields.
  always_comb begin
    cmd_c.op    = fb_op_t'(cmd_op);
    cmd_c.x     = cmd_x;
    cmd_c.y     = cmd_y;
    cmd_c.len   = cmd_len;
    cmd_c.color = cmd_color;
  end

  // In IDLE the address comes straight from the command so PIXEL writes on the accept edge.
  always_comb begin
    draw_x_c = pos_x_q[X_W-1:0];
    draw_y_c = pos_y_q[Y_W-1:0];
    if (state_q == ST_IDLE) begin
      draw_x_c = cmd_c.x;
      draw_y_c = cmd_c.y;
    end
  end

  fb_pixel_addr u_addr (
    .x_i        (draw_x_c),
    .y_i        (draw_y_c),
    .byte_idx_o (byte_idx_c),
    .bit_idx_o  (bit_idx_c)
  );

  // Draw FSM; line states write one pixel per cycle and stop at the panel edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      len_q   <= '0;
      color_q <= 1'b0;
      for (int i = 0; i < int'(FB_BYTES); i++) begin
        fb_q[i] <= 8'h00;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            color_q <= cmd_c.color;
            pos_x_q <= POS_W'(cmd_c.x);
            pos_y_q <= POS_W'(cmd_c.y);
            len_q   <= cmd_c.len;
            cnt_q   <= '0;
            case (cmd_c.op)
              FB_CLEAR: state_q <= ST_CLEAR;
              FB_PIXEL: begin
                fb_q[byte_idx_c][bit_idx_c] <= cmd_c.color;
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
              FB_HLINE: begin
                if (cmd_c.len == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_HLINE;
                end
              end
              FB_VLINE: begin
                if (cmd_c.len == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_VLINE;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_CLEAR: begin
          fb_q[cnt_q] <= {8{color_q}};
          if (cnt_q == ADDR_W'(FB_BYTES - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_HLINE: begin
          fb_q[byte_idx_c][bit_idx_c] <= color_q;
          if ((len_q == LEN_W'(1)) || (pos_x_q == POS_W'(FB_W - 1))) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            pos_x_q <= pos_x_q + POS_W'(1);
            len_q   <= len_q - LEN_W'(1);
          end
        end
        ST_VLINE: begin
          fb_q[byte_idx_c][bit_idx_c] <= color_q;
          if ((len_q == LEN_W'(1)) || (pos_y_q == POS_W'(FB_H - 1))) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            pos_y_q <= pos_y_q + POS_W'(1);
            len_q   <= len_q - LEN_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign frame_out = fb_q;

endmodule

// File: tb/tb_fb_draw_engine.sv
// Scoreboarded bench for fb_draw_engine: done timing and frame contents vs a pixel model.
module tb_fb_draw_engine;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [6:0] cmd_x = 7'd0;
  logic [5:0] cmd_y = 6'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       cmd_color = 1'b0;
  logic       done;
  logic [7:0] frame_out [0:1023];

  logic [7:0] model [0:1023];
  int         exp_q [$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  fb_draw_engine dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_len   (cmd_len),
    .cmd_color (cmd_color),
    .done      (done),
    .frame_out (frame_out)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Done-pulse monitor: pops the expected completion edge for each pulse.
  always @(negedge sys_clk) begin
    if (sys_rst_n && done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done=1 at edge %0d, required no pulse", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          n_fail++;
          $display("FAIL done_timing: pulse after edge %0d, required after edge %0d", cyc, e);
        end
      end
      n_tests++;
      if (cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL done_and_ready: cmd_ready=%b with done=1, required 0", cmd_ready);
      end
    end
  end

  function automatic void mset(int x, int y, logic c);
    model[y * 16 + x / 8][7 - (x % 8)] = c;
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
  endfunction

  // Wait for cmd_ready, drive one command across its accept edge, push its expected done edge.
  task automatic send_cmd(input int op, input int x, input int y, input int len, input logic c);
    int n;
    int nw;
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge sys_clk);
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%b after 3000 cycles, required 1", cmd_ready);
      return;
    end
    cmd_op = 2'(op); cmd_x = 7'(x); cmd_y = 6'(y); cmd_len = 8'(len); cmd_color = c;
    cmd_valid = 1'b1;
    n = cyc + 1;
    nw = 0;
    case (op)
      0: begin nw = 1024; for (int i = 0; i < 1024; i++) model[i] = {8{c}}; end
      1: mset(x, y, c);
      2: for (int i = 0; i < len && x + i <= 127; i++) begin mset(x + i, y, c); nw++; end
      default: for (int i = 0; i < len && y + i <= 63; i++) begin mset(x, y + i, c); nw++; end
    endcase
    exp_q.push_back(n + nw);
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait for every pushed command to complete; cmd_ready must stay low while any is pending.
  task automatic wait_idle(input string name);
    bit busy_bad;
    bit ok;
    busy_bad = 0;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge sys_clk);
      #2;
      if (exp_q.size() != 0 && cmd_ready === 1'b1) busy_bad = 1;
      if (exp_q.size() == 0 && cmd_ready === 1'b1) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d completions outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_tests++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL %s_ready_busy: cmd_ready=1 while busy, required 0", name);
    end
  endtask

  task automatic check_frame(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (frame_out[i] !== model[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_frame: %0d bytes differ, byte %0d = %h, required %h",
               name, bad, first, frame_out[first], model[first]);
    end
  endtask

  task automatic check_byte(input string name, input int idx, input logic [7:0] exp);
    n_tests++;
    if (frame_out[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s: byte %0d = %h, required %h", name, idx, frame_out[idx], exp);
    end
  endtask

  task automatic test_reset();
    model_zero();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_frame("reset");
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: done=%b, required 0", done);
    end
  endtask

  task automatic test_pixel();
    send_cmd(1, 0, 0, 0, 1'b1);
    check_byte("pixel_00_after_edge", 0, 8'h80);
    wait_idle("pixel_00");
    send_cmd(1, 127, 63, 0, 1'b1);
    wait_idle("pixel_127_63");
    check_byte("pixel_127_63", 1023, 8'h01);
    check_byte("pixel_byte0_kept", 0, 8'h80);
    send_cmd(1, 1, 0, 0, 1'b1);
    wait_idle("pixel_rmw_set");
    check_byte("pixel_rmw_set", 0, 8'hC0);
    send_cmd(1, 0, 0, 0, 1'b0);
    wait_idle("pixel_rmw_clr");
    check_byte("pixel_rmw_clr", 0, 8'h40);
    check_frame("pixel");
  endtask

  task automatic test_clear();
    send_cmd(0, 0, 0, 0, 1'b1);
    // A PIXEL presented while busy must be dropped.
    @(negedge sys_clk);
    cmd_op = 2'd1; cmd_x = 7'd0; cmd_y = 6'd0; cmd_color = 1'b0; cmd_valid = 1'b1;
    repeat (50) @(negedge sys_clk);
    cmd_valid = 1'b0;
    wait_idle("clear_on");
    check_byte("clear_on_byte0", 0, 8'hFF);
    check_frame("clear_on");
    send_cmd(0, 0, 0, 0, 1'b0);
    wait_idle("clear_off");
    check_frame("clear_off");
  endtask

  task automatic test_hline();
    send_cmd(2, 120, 32, 20, 1'b1);
    wait_idle("hline_clip");
    check_byte("hline_clip_527", 527, 8'hFF);
    check_byte("hline_clip_528", 528, 8'h00);
    check_byte("hline_clip_526", 526, 8'h00);
    send_cmd(2, 3, 5, 10, 1'b1);
    wait_idle("hline_mid");
    check_byte("hline_mid_80", 80, 8'h1F);
    check_byte("hline_mid_81", 81, 8'hF8);
    check_frame("hline");
  endtask

  task automatic test_vline();
    send_cmd(3, 9, 60, 0, 1'b1);
    wait_idle("vline_len0");
    check_frame("vline_len0");
    send_cmd(3, 9, 60, 10, 1'b1);
    wait_idle("vline_clip");
    check_byte("vline_961", 961, 8'h40);
    check_byte("vline_977", 977, 8'h40);
    check_byte("vline_993", 993, 8'h40);
    check_byte("vline_1009", 1009, 8'h40);
    check_byte("vline_nowrap_1", 1, 8'h00);
    check_frame("vline");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      int op;
      op = int'($urandom_range(1, 3));
      send_cmd(op, int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    end
    wait_idle("b2b");
    check_frame("b2b");
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    send_cmd(0, 0, 0, 0, 1'b1);
    repeat (300) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_zero();
    check_frame("rst_mid");
    done_seen = 0;
    repeat (2) begin
      @(negedge sys_clk);
      if (done !== 1'b0) done_seen = 1;
    end
    sys_rst_n = 1'b1;
    repeat (1100) begin
      @(negedge sys_clk);
      if (done !== 1'b0) done_seen = 1;
    end
    n_tests++;
    if (done_seen) begin
      n_fail++; $display("FAIL rst_mid_done: done=1 after aborted clear, required 0");
    end
    check_frame("rst_mid_after");
    send_cmd(1, 64, 40, 0, 1'b1);
    wait_idle("rst_mid_pixel");
    check_byte("rst_mid_pixel", 40 * 16 + 8, 8'h80);
    check_frame("rst_mid_pixel");
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_clear();
    test_hline();
    test_vline();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_draw_engine.md
Name: fb_draw_engine

Overview:
- Framebuffer owner and drawing engine for the 128x64 monochrome ST7920 panel.
- Accepts draw commands over a valid/ready interface: CLEAR/FILL, PIXEL, HLINE, VLINE.
- Holds the 1024-byte frame image and presents it continuously as an unpacked byte array.
- The array feeds the memory_in input of the downstream serial LCD driver.

Parameters:
- FB_W, 128, panel width in pixels (fixed by panel)
- FB_H, 64, panel height in pixels (fixed by panel)
- FB_BYTES, 1024, FB_W*FB_H/8

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=CLEAR, 1=PIXEL, 2=HLINE, 3=VLINE
- cmd_x  in  7  start column, 0..127
- cmd_y  in  6  start row, 0..63
- cmd_len  in  8  line length in pixels; ignored for CLEAR/PIXEL
- cmd_color  in  1  1=pixel on, 0=pixel off
- done  out  1  one-cycle pulse when a command completes
- frame_out  out  [7:0] x [0:1023]  framebuffer image

Behaviour:
- Reset is asynchronous and active-low; the block has one clock, sys_clk.
- Reset values: all frame_out bytes 8'h00, state IDLE, done 0, cmd_ready 1 once reset deasserts.
- Layout matches the driver: pixel (x,y) is byte y*16 + x[6:3], bit 7-x[2:0].
  - MSB is the leftmost pixel.
  - Bytes 0..511 hold rows 0..31; bytes 512..1023 hold rows 32..63.
- cmd_ready = (state == IDLE). A command is accepted on a sys_clk edge where cmd_valid && cmd_ready; all cmd_* fields are latched then.
- States: IDLE, CLEAR, HLINE, VLINE, DONE.
- PIXEL (no draw state):
  - Accepted at edge N; target bit written at edge N.
  - FSM goes to DONE; done=1 during cycle N+1; cmd_ready=0 during that cycle.
  - Back to IDLE at edge N+1.
- CLEAR:
  - Writes {8{color}} to byte k at edge N+1+k, for k = 0..1023.
  - Byte counter is 10 bits; last write at edge N+1024.
  - Then DONE: done high in cycle N+1025, IDLE after.
- HLINE:
  - One pixel per cycle: pixel i (x+i, y) written at edge N+1+i.
  - Stops after cmd_len pixels or after writing column 127, whichever comes first (clip, no wrap to the next row).
  - Then DONE.
- VLINE:
  - Same as HLINE along y; clips at row 63, no wrap.
- cmd_len = 0 for HLINE/VLINE: no framebuffer writes; IDLE -> DONE directly, so done is seen in cycle N+1.
- Pixel writes are read-modify-write on one byte. Only the addressed bit changes; the other 7 bits are held.
- Use 8-bit position counters for clip detection so that x+len arithmetic cannot overflow silently. Compare start+i against 127/63 before incrementing.
- cmd_valid while busy: ignored and not queued. The upstream must hold the command until it sees cmd_ready.
- Reset mid-operation: aborts immediately, framebuffer returns to all-zero, no done pulse.
- frame_out is a direct register view. The downstream samples it asynchronously to drawing, so tearing during a multi-cycle op is acceptable.
- done and cmd_ready are never both high.

Decomposition:
- Shared package st7920_pkg holds:
  - FB_W, FB_H, FB_BYTES, BYTES_PER_ROW=16
  - enum fb_op_t {FB_CLEAR, FB_PIXEL, FB_HLINE, FB_VLINE}
  - FSM state enum fb_state_t
- One sub-module is natural: fb_pixel_addr. It is combinational and maps (x,y) to (byte index [9:0], bit index [2:0]).
  - Instantiate it once for the current draw position.

Test Plan:
- Reset release -> all 1024 bytes 8'h00, cmd_ready=1, done=0.
- PIXEL x=0 y=0 color=1 -> byte 0 = 8'h80 after 1 edge; done pulse next cycle. Then PIXEL x=127 y=63 -> byte 1023 = 8'h01, byte 0 unchanged.
- CLEAR color=1 -> every byte 8'hFF; done exactly 1025 cycles after accept; cmd_ready low throughout.
- HLINE x=120 y=32 len=20 color=1 -> byte 527 = 8'hFF (8 pixels, clipped); byte 528 untouched; done after 8 writes.
- VLINE x=9 y=60 len=0 -> no writes, done one cycle after accept. Then VLINE x=9 y=60 len=10 -> bytes 961,977,993,1009 = 8'h40, clip at row 63.
- Assert sys_rst_n low midway through CLEAR color=1 -> framebuffer all 8'h00 immediately, no done pulse. After release, accept a new PIXEL normally.
